nrad_seq: RTL and testbench



---
 rtl/nrad_pkg.sv | 20 ++
 rtl/nrad_cas_row.sv | 26 ++
 rtl/nrad_seq.sv | 148 ++++++++++++++
 tb/tb_nrad_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nrad_pkg.sv
// Shared definitions for the sequential non-restoring divider: state encoding
// and the width legality rule applied when the divider is elaborated.
package nrad_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ITER = 2'd1;
   localparam logic [1:0] CORR = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_ITER = ITER,
      ST_CORR = CORR
   } state_t;

   // Dividend/quotient width 2..32, divisor/remainder width 1..dividend width.
   function automatic bit nrad_widths_ok(input int dw, input int vw);
      return (dw >= 2) && (dw <= 32) && (vw >= 1) && (vw <= dw);
   endfunction

endpackage

// File: rtl/nrad_cas_row.sv
// One controlled add/subtract row: r_new = s + d (sub=0) or s - d (sub=1),
// built as a ripple of CAS cells (XOR-conditioned operand into a full adder).
module nrad_cas_row #(
   parameter int W = 5
) (
   input  logic [W-1:0] s,
   input  logic [W-1:0] d,
   input  logic         sub,
   output logic [W-1:0] r_new
);

   logic [W-1:0] carry;

   // Subtraction is s + ~d + 1, so sub doubles as the row carry-in.
   assign carry[0] = sub;

   for (genvar gi = 0; gi < W; gi++) begin : g_cas
      logic b;
      assign b         = d[gi] ^ sub;
      assign r_new[gi] = s[gi] ^ b ^ carry[gi];
      if (gi < W - 1) begin : g_carry
         assign carry[gi+1] = (s[gi] & b) | (carry[gi] & (s[gi] ^ b));
      end
   end

endmodule

// File: rtl/nrad_seq.sv
// Sequential non-restoring unsigned divider: one shared CAS row produces one
// quotient bit per clock, with a final remainder correction step.
import nrad_pkg::*;

module nrad_seq #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW);

   if (!nrad_widths_ok(DW, VW)) begin : g_bad_widths
      $error("nrad_seq: illegal widths DW=%0d VW=%0d", DW, VW);
   end

   state_t        state_reg, state_next;
   logic [VW:0]   r_reg, r_next;
   logic [DW-1:0] q_reg, q_next;
   logic [VW-1:0] d_reg, d_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          dz_reg, dz_next;
   logic          done_reg, done_next;
   logic [DW-1:0] quo_reg, quo_next;
   logic [VW-1:0] rem_reg, rem_next;
   logic          dbz_reg, dbz_next;

   logic [VW:0]   row_s;
   logic [VW:0]   row_d;
   logic          row_sub;
   logic [VW:0]   row_out;

   // ITER shifts the next dividend bit into the partial remainder; CORR reuses
   // the same row as a plain add to restore a negative remainder.
   always_comb begin
      row_d = {1'b0, d_reg};
      if (state_reg == ST_ITER) begin
         row_s   = {r_reg[VW-1:0], q_reg[DW-1]};
         row_sub = ~r_reg[VW];
      end else begin
         row_s   = r_reg;
         row_sub = 1'b0;
      end
   end

   nrad_cas_row #(
      .W(VW + 1)
   ) u_row (
      .s    (row_s),
      .d    (row_d),
      .sub  (row_sub),
      .r_new(row_out)
   );

   always_comb begin
      state_next = state_reg;
      r_next     = r_reg;
      q_next     = q_reg;
      d_next     = d_reg;
      cnt_next   = cnt_reg;
      dz_next    = dz_reg;
      done_next  = 1'b0;
      quo_next   = quo_reg;
      rem_next   = rem_reg;
      dbz_next   = dbz_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               r_next     = '0;
               q_next     = dividend;
               d_next     = divisor;
               cnt_next   = CW'(DW - 1);
               dz_next    = (divisor == '0);
               state_next = (divisor == '0) ? ST_CORR : ST_ITER;
            end
         end
         ST_ITER: begin
            r_next   = row_out;
            q_next   = {q_reg[DW-2:0], ~row_out[VW]};
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
               state_next = ST_CORR;
            end
         end
         ST_CORR: begin
            // With a zero divisor Q still holds the untouched dividend.
            if (dz_reg) begin
               quo_next = '1;
               rem_next = q_reg[VW-1:0];
               dbz_next = 1'b1;
            end else begin
               quo_next = q_reg;
               rem_next = r_reg[VW] ? row_out[VW-1:0] : r_reg[VW-1:0];
               dbz_next = 1'b0;
            end
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         r_reg     <= '0;
         q_reg     <= '0;
         d_reg     <= '0;
         cnt_reg   <= '0;
         dz_reg    <= 1'b0;
         done_reg  <= 1'b0;
         quo_reg   <= '0;
         rem_reg   <= '0;
         dbz_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         q_reg     <= q_next;
         d_reg     <= d_next;
         cnt_reg   <= cnt_next;
         dz_reg    <= dz_next;
         done_reg  <= done_next;
         quo_reg   <= quo_next;
         rem_reg   <= rem_next;
         dbz_reg   <= dbz_next;
      end
   end

   assign busy        = (state_reg != ST_IDLE);
   assign done        = done_reg;
   assign quotient    = quo_reg;
   assign remainder   = rem_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_nrad_seq.sv
// Bench for nrad_seq: three width configurations, each checked every cycle
// against a quotient/remainder/latency model built from plain / and %.
module tb_nrad_seq;

   logic clk = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int DW = (gi == 0) ? 8 : (gi == 1) ? 4 : 16;
      localparam int VW = (gi == 0) ? 4 : (gi == 1) ? 2 : 8;

      logic          rst_n    = 1'b0;
      logic          start    = 1'b0;
      logic [DW-1:0] dividend = '0;
      logic [VW-1:0] divisor  = '0;
      logic          busy, done, div_by_zero;
      logic [DW-1:0] quotient;
      logic [VW-1:0] remainder;
      bit            fin = 1'b0;

      // literal expectations attached to the operands presented with start
      bit            tag_lit = 1'b0;
      logic [DW-1:0] tag_q   = '0;
      logic [VW-1:0] tag_r   = '0;
      bit            tag_z   = 1'b0;
      int            tag_lat = 0;

      nrad_seq #(.DW(DW), .VW(VW)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start),
         .dividend   (dividend),
         .divisor    (divisor),
         .busy       (busy),
         .done       (done),
         .quotient   (quotient),
         .remainder  (remainder),
         .div_by_zero(div_by_zero)
      );

      // model state
      int            cyc = 0;
      bit            inflight = 1'b0;
      bit            exp_busy = 1'b0, exp_done = 1'b0, exp_z = 1'b0;
      logic [DW-1:0] exp_q = '0;
      logic [VW-1:0] exp_r = '0;
      logic [DW-1:0] op_a = '0, done_a = '0;
      logic [VW-1:0] op_b = '0, done_b = '0;
      int            op_acc = 0, op_due = 0, done_acc = 0;
      bit            op_lit = 1'b0, done_lit = 1'b0;
      logic [DW-1:0] op_lq = '0, done_lq = '0;
      logic [VW-1:0] op_lr = '0, done_lr = '0;
      bit            op_lz = 1'b0, done_lz = 1'b0;
      int            op_llat = 0, done_llat = 0;
      bit            accept;

      initial forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            inflight = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
            exp_q = '0; exp_r = '0; exp_z = 1'b0; done_lit = 1'b0;
         end else begin
            cyc++;
            accept   = start && !exp_busy;
            exp_done = 1'b0;
            done_lit = 1'b0;
            if (inflight && cyc == op_due) begin
               exp_done = 1'b1;
               inflight = 1'b0;
               if (op_b == '0) begin
                  exp_q = '1;
                  exp_r = VW'(op_a);
                  exp_z = 1'b1;
               end else begin
                  exp_q = DW'(int'(op_a) / int'(op_b));
                  exp_r = VW'(int'(op_a) % int'(op_b));
                  exp_z = 1'b0;
               end
               done_a = op_a; done_b = op_b; done_acc = op_acc;
               done_lit = op_lit; done_lq = op_lq; done_lr = op_lr;
               done_lz = op_lz; done_llat = op_llat;
            end
            if (accept) begin
               op_a = dividend; op_b = divisor; op_acc = cyc;
               op_due = cyc + ((divisor == '0) ? 1 : DW + 1);
               inflight = 1'b1;
               op_lit = tag_lit; op_lq = tag_q; op_lr = tag_r;
               op_lz = tag_z; op_llat = tag_lat;
            end
            exp_busy = inflight;
         end
      end

      int lat_seen;
      initial forever begin
         @(negedge clk);
         n_tests++;
         if ({busy, done, div_by_zero, quotient, remainder} !==
             {exp_busy, exp_done, exp_z, exp_q, exp_r}) begin
            n_fail++;
            $display("FAIL cfg%0d outputs cycle %0d: got busy=%0d done=%0d z=%0d q=%0d r=%0d, expected busy=%0d done=%0d z=%0d q=%0d r=%0d",
                     gi, cyc, busy, done, div_by_zero, quotient, remainder,
                     exp_busy, exp_done, exp_z, exp_q, exp_r);
         end
         if (exp_done) begin
            $display("[TB] cfg%0d %0d / %0d -> q=%0d r=%0d z=%0d (accepted cycle %0d)",
                     gi, done_a, done_b, quotient, remainder, div_by_zero, done_acc);
            if (done_lit) begin
               lat_seen = done ? (cyc - done_acc) : -1;
               n_tests++;
               if ({quotient, remainder, div_by_zero} !== {done_lq, done_lr, done_lz} ||
                   lat_seen != done_llat) begin
                  n_fail++;
                  $display("FAIL cfg%0d literal %0d/%0d: got q=%0d r=%0d z=%0d lat=%0d, expected q=%0d r=%0d z=%0d lat=%0d",
                           gi, done_a, done_b, quotient, remainder, div_by_zero, lat_seen,
                           done_lq, done_lr, done_lz, done_llat);
               end
            end
         end
      end

      task automatic set_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit lit,
                            input logic [DW-1:0] lq, input logic [VW-1:0] lr,
                            input bit lz, input int llat);
         dividend = a; divisor = b;
         tag_lit = lit; tag_q = lq; tag_r = lr; tag_z = lz; tag_lat = llat;
      endtask

      task automatic wait_idle();
         for (int k = 0; k < DW + 6 && exp_busy; k++) @(negedge clk);
      endtask

      task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit lit,
                           input logic [DW-1:0] lq, input logic [VW-1:0] lr,
                           input bit lz, input int llat);
         @(negedge clk); #1;
         set_op(a, b, lit, lq, lr, lz, llat);
         start = 1'b1;
         @(negedge clk); #1;
         start = 1'b0;
         set_op(DW'($urandom), VW'($urandom), 1'b0, '0, '0, 1'b0, 0);
         wait_idle();
      endtask

      task automatic do_reset();
         rst_n = 1'b0;
         repeat (2) @(negedge clk);
         #1 rst_n = 1'b1;
      endtask

      task automatic rand_phase(input int n);
         for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            start    = ($urandom_range(0, 2) == 0);
            dividend = DW'($urandom);
            divisor  = ($urandom_range(0, 9) == 0) ? '0 : VW'($urandom);
         end
         @(negedge clk); #1;
         start = 1'b0;
         repeat (DW + 4) @(negedge clk);
      endtask

      if (gi == 0) begin : g_directed
         initial begin
            do_reset();
            do_op(200, 7, 1, 28, 4, 0, 9);
            do_op(255, 1, 1, 255, 0, 0, 9);
            do_op(5, 9, 1, 0, 5, 0, 9);
            do_op(0, 15, 1, 0, 0, 0, 9);
            do_op(8'hA6, 0, 1, 8'hFF, 6, 1, 1);
            do_op(10, 3, 1, 3, 1, 0, 9);
            // start while busy must be ignored
            @(negedge clk); #1;
            set_op(100, 3, 1, 33, 1, 0, 9);
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
            repeat (2) @(negedge clk);
            #1 set_op(50, 5, 0, '0, '0, 0, 0);
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
            wait_idle();
            // start held through done: back-to-back accept
            @(negedge clk); #1;
            set_op(100, 3, 1, 33, 1, 0, 9);
            start = 1'b1;
            @(negedge clk); #1;
            set_op(77, 6, 1, 12, 5, 0, 9);
            wait_idle();
            @(negedge clk); #1;
            start = 1'b0;
            wait_idle();
            // asynchronous abort in the middle of an operation
            @(negedge clk); #1;
            set_op(200, 7, 0, '0, '0, 0, 0);
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b0;
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b1;
            do_op(200, 7, 1, 28, 4, 0, 9);
            rand_phase(400);
            fin = 1'b1;
         end
      end else if (gi == 1) begin : g_sweep
         initial begin
            do_reset();
            for (int a = 0; a < 16; a++) begin
               for (int b = 0; b < 4; b++) begin
                  do_op(DW'(a), VW'(b), 0, '0, '0, 0, 0);
               end
            end
            fin = 1'b1;
         end
      end else begin : g_random
         initial begin
            do_reset();
            rand_phase(1500);
            fin = 1'b1;
         end
      end
   end

   initial begin
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
      end
      #2;
      n_tests++;
      if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
         n_fail++;
         $display("FAIL timeout: got fin=%0d%0d%0d, expected 111",
                  g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
